step_sequence_decoder: RTL and testbench

//   Receive-side observer for the 2-bit step value driven by the 4-step sequencer (values 0..3).

---
 rtl/step_sequence_decoder_if.sv | 24 ++
 rtl/step_sequence_decoder.sv | 107 ++++++++++
 tb/tb_step_sequence_decoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/step_sequence_decoder_if.sv
// step_sequence_decoder_if: step-value sample stream in, classification pulses and status out
interface step_sequence_decoder_if #(parameter int CNT_W = 8);
  logic [1:0]       iVal;
  logic             iValid;
  logic             iClr;
  logic             oHold;
  logic             oFwd;
  logic             oWrap;
  logic             oBack;
  logic             oRstJmp;
  logic             oIllegal;
  logic             oLocked;
  logic             oErr;
  logic [CNT_W-1:0] oFwdCnt;
  logic [CNT_W-1:0] oBackCnt;
  modport master (
    output iVal, iValid, iClr,
    input  oHold, oFwd, oWrap, oBack, oRstJmp, oIllegal, oLocked, oErr, oFwdCnt, oBackCnt
  );
  modport slave (
    input  iVal, iValid, iClr,
    output oHold, oFwd, oWrap, oBack, oRstJmp, oIllegal, oLocked, oErr, oFwdCnt, oBackCnt
  );
endinterface

// File: rtl/step_sequence_decoder.sv
// step_sequence_decoder: classifies 4-step sequencer value changes, tracks lock, counts steps
module step_sequence_decoder #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input logic iclk,
  input logic irst,
  step_sequence_decoder_if.slave bus
);
  typedef enum logic [1:0] {UNSYNC, ACQ, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic [3:0]       lock_q, lock_d;
  logic             hold_q, hold_d, fwd_q, fwd_d, wrap_q, wrap_d, back_q, back_d;
  logic             rstjmp_q, rstjmp_d, illegal_q, illegal_d, locked_q, locked_d, err_q, err_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d, back_cnt_q, back_cnt_d;
  logic             is_hold, is_fwd, is_back, is_rstjmp, is_illegal, cls_en;
  // Classify prev -> new; 0->3 is not a legal backward step for the sequencer
  always_comb begin
    is_hold    = bus.iVal == prev_q;
    is_fwd     = bus.iVal == prev_q + 2'd1;
    is_back    = (bus.iVal == prev_q - 2'd1) && (prev_q != 2'd0);
    is_rstjmp  = (prev_q == 2'd2) && (bus.iVal == 2'd0);
    is_illegal = !(is_hold || is_fwd || is_back || is_rstjmp);
    cls_en     = bus.iValid && (state_q != UNSYNC);
  end
  // Next-state: pulses, lock acquisition, saturating counters, sticky error with clear priority
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    lock_d     = lock_q;
    err_d      = err_q;
    fwd_cnt_d  = fwd_cnt_q;
    back_cnt_d = back_cnt_q;
    hold_d     = cls_en && is_hold;
    fwd_d      = cls_en && is_fwd;
    wrap_d     = cls_en && is_fwd && (prev_q == 2'd3);
    back_d     = cls_en && is_back;
    rstjmp_d   = cls_en && is_rstjmp;
    illegal_d  = cls_en && is_illegal;
    if (bus.iValid) begin
      prev_d = bus.iVal;
      if (state_q == UNSYNC) begin
        state_d = ACQ;
        lock_d  = '0;
      end else if (is_illegal) begin
        err_d   = err_q || (state_q == LOCKED);
        state_d = ACQ;
        lock_d  = '0;
      end else if (state_q == ACQ) begin
        lock_d  = is_hold ? lock_q : lock_q + 4'd1;
        state_d = (!is_hold && (lock_q + 4'd1 == 4'(LOCK_CNT))) ? LOCKED : ACQ;
      end else begin
        fwd_cnt_d  = (is_fwd && fwd_cnt_q != '1) ? fwd_cnt_q + 1'b1 : fwd_cnt_q;
        back_cnt_d = (is_back && back_cnt_q != '1) ? back_cnt_q + 1'b1 : back_cnt_q;
      end
    end
    if (bus.iClr) begin
      fwd_cnt_d  = '0;
      back_cnt_d = '0;
      err_d      = 1'b0;
    end
    locked_d = state_d == LOCKED;
  end
  // State and registered outputs, asynchronously cleared
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q    <= UNSYNC;
      prev_q     <= '0;
      lock_q     <= '0;
      hold_q     <= 1'b0;
      fwd_q      <= 1'b0;
      wrap_q     <= 1'b0;
      back_q     <= 1'b0;
      rstjmp_q   <= 1'b0;
      illegal_q  <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      fwd_cnt_q  <= '0;
      back_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      lock_q     <= lock_d;
      hold_q     <= hold_d;
      fwd_q      <= fwd_d;
      wrap_q     <= wrap_d;
      back_q     <= back_d;
      rstjmp_q   <= rstjmp_d;
      illegal_q  <= illegal_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      fwd_cnt_q  <= fwd_cnt_d;
      back_cnt_q <= back_cnt_d;
    end
  end
  assign bus.oHold    = hold_q;
  assign bus.oFwd     = fwd_q;
  assign bus.oWrap    = wrap_q;
  assign bus.oBack    = back_q;
  assign bus.oRstJmp  = rstjmp_q;
  assign bus.oIllegal = illegal_q;
  assign bus.oLocked  = locked_q;
  assign bus.oErr     = err_q;
  assign bus.oFwdCnt  = fwd_cnt_q;
  assign bus.oBackCnt = back_cnt_q;
endmodule

// File: tb/tb_step_sequence_decoder.sv
// tb_step_sequence_decoder: scoreboard-driven bench for the step sequence decoder
module tb_step_sequence_decoder;
  localparam int CW = 2;
  localparam int LK = 2;
  localparam int OW = 8 + 2 * CW;
  logic iclk = 1'b0;
  logic irst = 1'b0;
  always #5 iclk = ~iclk;
  step_sequence_decoder_if #(.CNT_W(CW)) bus ();
  step_sequence_decoder #(.CNT_W(CW), .LOCK_CNT(LK)) dut (.iclk(iclk), .irst(irst), .bus(bus));
  int errors = 0;
  int checks = 0;
  // Reference model state: 0=UNSYNC 1=ACQ 2=LOCKED
  int            m_state, m_lock;
  logic [1:0]    m_prev;
  logic          m_err;
  logic [CW-1:0] m_f, m_b;
  logic [OW-1:0] sbq[$];
  // Class per [prev][new]: 0 hold, 1 fwd, 2 back, 3 rstjmp, 4 illegal
  int cls_tab [4][4] = '{'{0, 1, 4, 4}, '{2, 0, 1, 4}, '{3, 2, 0, 1}, '{1, 4, 2, 0}};

  function automatic logic [OW-1:0] observed();
    return {bus.oHold, bus.oFwd, bus.oWrap, bus.oBack, bus.oRstJmp, bus.oIllegal,
            bus.oLocked, bus.oErr, bus.oFwdCnt, bus.oBackCnt};
  endfunction

  task automatic model_reset();
    m_state = 0; m_lock = 0; m_prev = 2'd0; m_err = 1'b0; m_f = '0; m_b = '0;
  endtask

  // Drive one cycle, push model expectation, pop and compare after the edge
  task automatic step(input logic v, input logic [1:0] val, input logic c);
    logic [OW-1:0] exp_v, got_v;
    logic [5:0]    p;
    int            k;
    bus.iValid = v; bus.iVal = val; bus.iClr = c;
    k = cls_tab[m_prev][val];
    p = '0;
    if (v && m_state != 0) p = {k == 0, k == 1, k == 1 && m_prev == 2'd3, k == 2, k == 3, k == 4};
    if (v) begin
      if (m_state == 0) begin
        m_state = 1; m_lock = 0;
      end else if (k == 4) begin
        if (m_state == 2) m_err = 1'b1;
        m_state = 1; m_lock = 0;
      end else if (m_state == 1) begin
        if (k != 0) begin
          m_lock = m_lock + 1;
          if (m_lock == LK) m_state = 2;
        end
      end else begin
        if (k == 1 && m_f != '1) m_f = m_f + 1'b1;
        if (k == 2 && m_b != '1) m_b = m_b + 1'b1;
      end
      m_prev = val;
    end
    if (c) begin m_f = '0; m_b = '0; m_err = 1'b0; end
    sbq.push_back({p, m_state == 2, m_err, m_f, m_b});
    @(posedge iclk); #1;
    exp_v = sbq.pop_front();
    got_v = observed();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL step v=%0b val=%0d clr=%0b: got %b expected %b (hold,fwd,wrap,back,rj,ill,lock,err,fc,bc)",
               v, val, c, got_v, exp_v);
    end
  endtask

  task automatic test_reset();
    bus.iValid = 1'b0; bus.iVal = 2'd0; bus.iClr = 1'b0;
    irst = 1'b0;
    model_reset();
    #2;
    checks++;
    if (observed() !== '0) begin errors++; $display("FAIL reset_outputs: got %b expected 0", observed()); end
    #5 irst = 1'b1;
  endtask

  task automatic test_forward();
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    checks++;
    if (bus.oLocked !== 1'b1) begin errors++; $display("FAIL lock_after_2fwd: got %b expected 1", bus.oLocked); end
    step(1'b1, 2'd3, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    checks++;
    if (bus.oFwdCnt !== 2'd2) begin errors++; $display("FAIL fwd_cnt: got %0d expected 2", bus.oFwdCnt); end
  endtask

  task automatic test_back_illegal();
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    checks++;
    if (bus.oBackCnt !== 2'd2) begin errors++; $display("FAIL back_cnt: got %0d expected 2", bus.oBackCnt); end
    step(1'b1, 2'd3, 1'b0);
    checks++;
    if ({bus.oIllegal, bus.oErr, bus.oLocked} !== 3'b110) begin
      errors++; $display("FAIL illegal_locked: got ill/err/lock=%b expected 110", {bus.oIllegal, bus.oErr, bus.oLocked});
    end
  endtask

  task automatic test_rstjmp();
    step(1'b1, 2'd0, 1'b1);
    checks++;
    if (bus.oErr !== 1'b0) begin errors++; $display("FAIL clr_err: got %b expected 0", bus.oErr); end
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    checks++;
    if ({bus.oRstJmp, bus.oLocked, bus.oFwdCnt, bus.oBackCnt} !== {1'b1, 1'b1, 2'd1, 2'd0}) begin
      errors++; $display("FAIL rstjmp: got rj/lock/fc/bc=%b expected 11_01_00",
                         {bus.oRstJmp, bus.oLocked, bus.oFwdCnt, bus.oBackCnt});
    end
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 5; i++) step(1'b1, 2'(i), 1'b0);
    checks++;
    if (bus.oFwdCnt !== 2'd3) begin errors++; $display("FAIL fwd_sat: got %0d expected 3", bus.oFwdCnt); end
    step(1'b1, 2'd2, 1'b1);
    checks++;
    if ({bus.oFwd, bus.oFwdCnt} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL clr_priority: got fwd/fc=%b expected 100", {bus.oFwd, bus.oFwdCnt});
    end
  endtask

  task automatic test_idle_acq();
    for (int i = 0; i < 10; i++) step(1'b0, 2'($urandom_range(0, 3)), 1'b0);
    step(1'b1, 2'd2, 1'b0);
    checks++;
    if (bus.oHold !== 1'b1) begin errors++; $display("FAIL prev_kept: got hold=%b expected 1", bus.oHold); end
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    checks++;
    if (bus.oLocked !== 1'b0) begin errors++; $display("FAIL hold_no_lock: got %b expected 0", bus.oLocked); end
    step(1'b1, 2'd1, 1'b0);
    checks++;
    if (bus.oLocked !== 1'b1) begin errors++; $display("FAIL relock: got %b expected 1", bus.oLocked); end
  endtask

  task automatic test_async_reset();
    #3 irst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (observed() !== '0) begin errors++; $display("FAIL async_reset: got %b expected 0", observed()); end
    #1 irst = 1'b1;
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_back_illegal();
    test_rstjmp();
    test_saturate();
    test_idle_acq();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
